// File: rtl/pc_sequencer_if.sv
// Interface bundling the control-unit side of the PC sequencer.
//   master : control unit; drives Stall/PCSrc/Imm/Addr/JumpRegister and observes
//            the PC, EPC and RAS status.
//   slave  : the sequencer itself.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              Stall;
  logic [2:0]        PCSrc;
  logic [31:0]       Imm;
  logic [25:0]       Addr;
  logic [ADDR_W-1:0] JumpRegister;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus4;
  logic [ADDR_W-1:0] EPC;
  logic [4:0]        RasCount;
  logic              RasOverflow;
  logic              RasUnderflow;
  logic              AlignFault;

  modport master (
    output Stall, PCSrc, Imm, Addr, JumpRegister,
    input  PC, PCPlus4, EPC, RasCount, RasOverflow, RasUnderflow, AlignFault
  );

  modport slave (
    input  Stall, PCSrc, Imm, Addr, JumpRegister,
    output PC, PCPlus4, EPC, RasCount, RasOverflow, RasUnderflow, AlignFault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owned PC register, stall, trap/ERET with EPC and a
// circular return-address stack for JAL/RET.
//   CLK   : clock, all state on rising edge
//   Reset : asynchronous, active-low
//   bus   : pc_sequencer_if.slave (control inputs, PC/EPC/RAS status outputs)
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       TRAP_VECTOR = 32'h0000_0080,
  parameter int unsigned       RAS_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] TrapVec = ADDR_W'(TRAP_VECTOR);

  typedef enum logic [2:0] {
    SrcSeq  = 3'b000,
    SrcBr   = 3'b001,
    SrcJ    = 3'b010,
    SrcJr   = 3'b011,
    SrcJal  = 3'b100,
    SrcRet  = 3'b101,
    SrcTrap = 3'b110,
    SrcEret = 3'b111
  } pc_src_e;

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, align_q, align_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              ras_we;

  logic [ADDR_W-1:0] pc_plus4, br_off, j_target;
  logic [PtrW-1:0]   ptr_inc, ptr_dec;
  logic              jr_misaligned;
  logic signed [31:0] imm_s;

  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign imm_s         = bus.Imm;
  // Signed cast sign-extends the word offset to the PC width before scaling.
  assign br_off        = ADDR_W'(imm_s) << 2;
  assign j_target      = {pc_plus4[ADDR_W-1:28], bus.Addr, 2'b00};
  assign jr_misaligned = |bus.JumpRegister[1:0];
  assign ptr_inc       = (top_q == PtrW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign ptr_dec       = (top_q == '0) ? PtrW'(RAS_DEPTH - 1) : top_q - 1'b1;

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    align_d = 1'b0;
    ras_we  = 1'b0;
    if (!bus.Stall) begin
      unique case (pc_src_e'(bus.PCSrc))
        SrcSeq: pc_d = pc_plus4;
        SrcBr:  pc_d = pc_plus4 + br_off;
        SrcJ:   pc_d = j_target;
        SrcJr: begin
          if (jr_misaligned) begin
            pc_d    = TrapVec;
            epc_d   = pc_q;
            align_d = 1'b1;
          end else begin
            pc_d = bus.JumpRegister;
          end
        end
        SrcJal: begin
          pc_d   = j_target;
          ras_we = 1'b1;
          top_d  = ptr_inc;
          // A full stack silently drops its oldest entry by wrapping the pointer.
          if (cnt_q < 5'(RAS_DEPTH)) cnt_d = cnt_q + 5'd1;
          else                       ovf_d = 1'b1;
        end
        SrcRet: begin
          if (cnt_q != 5'd0) begin
            pc_d  = ras_q[top_q];
            top_d = ptr_dec;
            cnt_d = cnt_q - 5'd1;
          end else begin
            unf_d = 1'b1;
            if (jr_misaligned) begin
              pc_d    = TrapVec;
              epc_d   = pc_q;
              align_d = 1'b1;
            end else begin
              pc_d = bus.JumpRegister;
            end
          end
        end
        SrcTrap: begin
          pc_d  = TrapVec;
          epc_d = pc_q;
        end
        SrcEret: pc_d = epc_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      align_q <= align_d;
    end
  end

  // Stack storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge CLK) begin
    if (ras_we) ras_q[top_d] <= pc_plus4;
  end

  assign bus.PC           = pc_q;
  assign bus.PCPlus4      = pc_plus4;
  assign bus.EPC          = epc_q;
  assign bus.RasCount     = cnt_q;
  assign bus.RasOverflow  = ovf_q;
  assign bus.RasUnderflow = unf_q;
  assign bus.AlignFault   = align_q;

endmodule
